// File: rtl/gnot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gnot_arbiter_pkg
// Brief    : State encodings, default sizes and ring-pointer helper shared by
//            the gnot arbiter files.
// Revision : 1.0 - initial release
// ============================================================================
package gnot_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam int c_default_n   = 4;
  localparam int c_default_w   = 1;
  localparam int c_default_idw = 2;

  // Next round-robin start index: one past the last winner, wrapping at n.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gnot.sv
`default_nettype none
// ============================================================================
// Module   : gnot
// Brief    : Single-bit inverter cell shared by the arbiter datapath.
// Revision : 1.0 - initial release
// ============================================================================
module gnot (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule
`default_nettype wire

// File: rtl/gnot_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : gnot_rr_pick
// Brief    : Combinational round-robin picker; first set request at or after
//            ptr, wrapping through N-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module gnot_rr_pick
  import gnot_arbiter_pkg::*;
#(
  parameter int N   = c_default_n,
  parameter int IDW = c_default_idw
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  int w_j;

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    w_j    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(ptr) + k) % N;
      if (req[w_j]) begin
        any         = 1'b1;
        idx         = IDW'(w_j);
        onehot      = '0;
        onehot[w_j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gnot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gnot_arbiter
// Brief    : Round-robin arbiter sharing one W-bit gnot inverter array among
//            N requesters; returns ~operand tagged with the requester index.
// Revision : 1.0 - initial release
// ============================================================================
module gnot_arbiter
  import gnot_arbiter_pkg::*;
#(
  parameter int N   = c_default_n,
  parameter int W   = c_default_w,
  parameter int IDW = c_default_idw
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_bus,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic [IDW-1:0] y_id,
  output logic           busy
);

  state_t         r_state;
  logic [W-1:0]   r_op;
  logic [IDW-1:0] r_cur_id;
  logic [IDW-1:0] r_ptr;

  logic           w_any;
  logic [IDW-1:0] w_idx;
  logic [N-1:0]   w_onehot;
  logic [W-1:0]   w_operand;
  logic [W-1:0]   w_inv;

  gnot_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .any    (w_any),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  assign w_operand = a_bus[int'(w_idx) * W +: W];

  for (genvar j = 0; j < W; j++) begin : g_inv
    gnot u_gnot (
      .a (r_op[j]),
      .y (w_inv[j])
    );
  end

  // Requests are only looked at in IDLE, so one operation takes two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_cur_id <= '0;
      r_ptr    <= '0;
      gnt      <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      y_id     <= '0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          y_valid <= 1'b0;
          if (w_any) begin
            r_op     <= w_operand;
            r_cur_id <= w_idx;
            gnt      <= w_onehot;
            busy     <= 1'b1;
            r_state  <= ST_EXEC;
          end else begin
            gnt <= '0;
          end
        end
        ST_EXEC: begin
          y       <= w_inv;
          y_id    <= r_cur_id;
          y_valid <= 1'b1;
          gnt     <= '0;
          busy    <= 1'b0;
          r_ptr   <= IDW'(rr_next(int'(r_cur_id), N));
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gnot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gnot_arbiter
// Brief    : Directed bench for gnot_arbiter (N=4, W=4) with a result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gnot_arbiter;

  localparam int c_n   = 4;
  localparam int c_w   = 4;
  localparam int c_idw = 2;

  typedef struct packed {
    logic [c_idw-1:0] id;
    logic [c_w-1:0]   y;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [c_n-1:0]     req;
  logic [c_n*c_w-1:0] a_bus;
  logic [c_n-1:0]     gnt;
  logic [c_w-1:0]     y;
  logic               y_valid;
  logic [c_idw-1:0]   y_id;
  logic               busy;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  gnot_arbiter #(
    .N   (c_n),
    .W   (c_w),
    .IDW (c_idw)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_bus   (a_bus),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid),
    .y_id    (y_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every y_valid pulse must match the oldest outstanding expected result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (y_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_y_valid", {14'd0, y_id}, 16'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("result_y", {12'd0, y}, {12'd0, e.y});
        chk("result_id", {14'd0, y_id}, {14'd0, e.id});
      end
    end
  end

  task automatic chk_idle_outputs(input string tag, input logic [3:0] exp_y);
    chk({tag, "_gnt"}, {12'd0, gnt}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_y_valid"}, {15'd0, y_valid}, 16'd0);
    chk({tag, "_y"}, {12'd0, y}, {12'd0, exp_y});
  endtask

  // One full operation: grant edge then EXEC edge, req dropped before EXEC.
  task automatic serve(input string tag, input logic [3:0] r, input logic [3:0] exp_gnt,
                       input logic [1:0] exp_id, input logic [3:0] exp_y);
    exp_t e;
    req = r;
    e.id = exp_id;
    e.y  = exp_y;
    exp_q.push_back(e);
    tick();
    chk({tag, "_gnt"}, {12'd0, gnt}, {12'd0, exp_gnt});
    chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
    req = 4'b0000;
    tick();
    chk({tag, "_gnt_drop"}, {12'd0, gnt}, 16'd0);
    chk({tag, "_busy_drop"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    exp_t e;
    rst   = 1'b1;
    req   = 4'b1111;
    a_bus = 16'h0000;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle_outputs("reset", 4'b0000);
      chk("reset_y_id", {14'd0, y_id}, 16'd0);
    end

    // Fairness from ptr=0: requester i carries operand 1<<i.
    rst   = 1'b0;
    a_bus = 16'h8421;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] onehot_k;
      logic [3:0] op_k;
      onehot_k = 4'b0001 << (k % 4);
      op_k     = 4'b0001 << (k % 4);
      e.id = 2'(k % 4);
      e.y  = ~op_k;
      exp_q.push_back(e);
      tick();
      chk("fair_gnt", {12'd0, gnt}, {12'd0, onehot_k});
      chk("fair_busy", {15'd0, busy}, 16'd1);
      if (k == 4) req = 4'b0000;
      tick();
      chk("fair_gnt_gap", {12'd0, gnt}, 16'd0);
    end
    tick();
    chk_idle_outputs("fair_end", 4'b1110);

    // Single request on requester 2 (ptr=1, so 1 is skipped); operand changed after grant.
    a_bus = 16'h0A00;
    req   = 4'b0100;
    e.id = 2'd2;
    e.y  = 4'b0101;
    exp_q.push_back(e);
    tick();
    chk("single_gnt", {12'd0, gnt}, 16'b0100);
    chk("single_busy", {15'd0, busy}, 16'd1);
    req   = 4'b0000;
    a_bus = 16'hFFFF;
    tick();
    tick();
    chk_idle_outputs("single_hold1", 4'b0101);
    tick();
    chk_idle_outputs("single_hold2", 4'b0101);

    // Wrap and skip: ptr=3 -> requester 1; then ptr=2 with req 0011 wraps to 0 then 1.
    a_bus = 16'h0030;
    serve("wrap_r1", 4'b0010, 4'b0010, 2'd1, 4'b1100);
    a_bus = 16'h0096;
    e.id = 2'd0;
    e.y  = 4'b1001;
    exp_q.push_back(e);
    e.id = 2'd1;
    e.y  = 4'b0110;
    exp_q.push_back(e);
    req = 4'b0011;
    tick();
    chk("wrap_gnt0", {12'd0, gnt}, 16'b0001);
    tick();
    chk("wrap_gap", {12'd0, gnt}, 16'd0);
    tick();
    chk("wrap_gnt1", {12'd0, gnt}, 16'b0010);
    req = 4'b0000;
    tick();
    tick();
    chk_idle_outputs("wrap_end", 4'b0110);

    // Data extremes: ptr=2 -> requester 3 with 0000, then ptr=0 -> requester 0 with 1111.
    a_bus = 16'h0FFF;
    serve("ext_zero", 4'b1000, 4'b1000, 2'd3, 4'b1111);
    a_bus = 16'h000F;
    serve("ext_ones", 4'b0001, 4'b0001, 2'd0, 4'b0000);
    tick();
    chk_idle_outputs("ext_end", 4'b0000);

    // Reset during EXEC: ptr=1 grants requester 2, result is discarded.
    a_bus = 16'h0500;
    req   = 4'b0100;
    tick();
    chk("rstmid_gnt", {12'd0, gnt}, 16'b0100);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    chk_idle_outputs("rstmid", 4'b0000);
    rst = 1'b0;
    tick();
    chk_idle_outputs("rstmid_after", 4'b0000);
    a_bus = 16'h5070;
    serve("rstmid_ptr0", 4'b1010, 4'b0010, 2'd1, 4'b1000);
    tick();
    chk_idle_outputs("rstmid_end", 4'b1000);

    // Reset coinciding with a would-be grant cancels it.
    req = 4'b1111;
    rst = 1'b1;
    tick();
    chk_idle_outputs("rstgnt", 4'b0000);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    chk_idle_outputs("rstgnt_after", 4'b0000);

    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
